// File: rtl/fifo_read_port.sv
// Read-side consumer for the dual-clock FIFO memory: issues reads, absorbs the
// one-cycle memory latency and presents words as a valid/ready stream via a 2-entry buffer.
module fifo_read_port #(
  parameter int DWIDTH   = 8,
  parameter int CNTWIDTH = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                empty,
  output logic                r_enable,
  input  logic [DWIDTH-1:0]   rdata,
  output logic [DWIDTH-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [CNTWIDTH-1:0] rd_count,
  output logic                busy
);

  logic              inflight;
  logic [1:0]        occ;
  logic [DWIDTH-1:0] buf0;
  logic [DWIDTH-1:0] buf1;
  logic              pop;
  logic [2:0]        level_next;

  assign dout_valid = (occ != 2'd0);
  assign dout       = buf0;
  assign busy       = inflight || (occ != 2'd0);

  // Only request a word when it is guaranteed a buffer slot after this edge's pop.
  always_comb begin
    pop        = dout_valid && dout_ready;
    level_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    r_enable   = !rrst && !empty && (level_next < 3'd2);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
      rd_count <= '0;
    end else begin
      inflight <= r_enable;
      occ      <= level_next[1:0];
      rd_count <= rd_count + {{(CNTWIDTH-1){1'b0}}, pop};
      // Captured word lands in the slot just behind the head as seen after the pop.
      case ({inflight, pop})
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= rdata;
          end else begin
            buf0 <= rdata;
          end
        end
        2'b01: begin
          buf0 <= buf1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            buf0 <= rdata;
          end else if (occ == 2'd1) begin
            buf1 <= rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
